sys_bridge_n: RTL and testbench

SYS_BRIDGE_N -- requirements
Module: sys_bridge_n

---
 rtl/sys_bridge_n.sv | 219 +++++++++++++++++++++
 tb/tb_sys_bridge_n.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bridge_n
//  Description : CPU-to-device bridge. Decodes a CPU access into one of NDEV
//                device slots or a control slot (MASK / PEND / ERRCNT), runs a
//                fixed-latency handshake and aggregates device interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_bridge_n #(
    parameter int          NDEV = 3,
    parameter int          WAIT = 1,
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pr_req,
    input  logic                pr_we,
    input  logic [31:0]         pr_addr,
    input  logic [31:0]         pr_wd,
    output logic [31:0]         pr_rd,
    output logic                pr_ready,
    output logic                pr_err,
    output logic [1:0]          dev_addr,
    output logic [31:0]         dev_wd,
    output logic [NDEV-1:0]     dev_we,
    input  logic [32*NDEV-1:0]  dev_rd,
    input  logic [NDEV-1:0]     dev_irq,
    output logic [5:0]          hw_int
);

    // Window spans NDEV device slots plus the trailing control slot.
    localparam logic [31:0] C_WIN_BYTES = 32'(16 * (NDEV + 1));
    localparam logic [2:0]  C_CTRL_SLOT = 3'(NDEV);
    localparam logic [2:0]  C_WAIT_LAST = 3'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic               miss_q, miss_d;
    logic               ctrl_q, ctrl_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic [1:0]         dev_addr_q, dev_addr_d;
    logic [31:0]        dev_wd_q, dev_wd_d;
    logic [NDEV-1:0]    dev_we_q, dev_we_d;
    logic [31:0]        pr_rd_q, pr_rd_d;
    logic               pr_ready_q, pr_ready_d;
    logic               pr_err_q, pr_err_d;
    logic [NDEV-1:0]    mask_q, mask_d;
    logic [NDEV-1:0]    pend_q, pend_d;
    logic [NDEV-1:0]    pend_clr;
    logic [7:0]         errcnt_q, errcnt_d;
    logic [5:0]         hw_int_q, hw_int_d;

    logic [31:0]        addr_off;
    logic               addr_hit;
    logic [2:0]         addr_slot;
    logic               dev_read;
    logic [31:0]        dev_rd_sel;
    logic [31:0]        ctrl_rd;

    // Address decode of the live request (only used while IDLE).
    assign addr_off  = pr_addr - BASE;
    assign addr_hit  = (pr_addr >= BASE) && (addr_off < C_WIN_BYTES);
    assign addr_slot = addr_off[6:4];
    assign dev_read  = !miss_q && !ctrl_q && !we_q;

    // Read-data muxes: selected device slice and zero-extended control word.
    always_comb begin
        dev_rd_sel = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (idx_q == 3'(i)) begin
                dev_rd_sel = dev_rd[32*i +: 32];
            end
        end
        ctrl_rd = '0;
        case (dev_addr_q)
            2'd0:    ctrl_rd[NDEV-1:0] = mask_q;
            2'd1:    ctrl_rd[NDEV-1:0] = pend_q;
            2'd2:    ctrl_rd[7:0]      = errcnt_q;
            default: ctrl_rd           = '0;
        endcase
    end

    // Next-state and datapath: IDLE latches/decodes, ACCESS performs, DONE handshakes.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        miss_d     = miss_q;
        ctrl_d     = ctrl_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        dev_we_d   = '0;
        pr_rd_d    = pr_rd_q;
        pr_ready_d = 1'b0;
        pr_err_d   = 1'b0;
        mask_d     = mask_q;
        errcnt_d   = errcnt_q;
        pend_clr   = '0;

        case (state_q)
            S_IDLE: begin
                if (pr_req) begin
                    state_d    = S_ACCESS;
                    we_d       = pr_we;
                    miss_d     = !addr_hit;
                    ctrl_d     = addr_hit && (addr_slot == C_CTRL_SLOT);
                    idx_d      = addr_slot;
                    wcnt_d     = '0;
                    dev_addr_d = pr_addr[3:2];
                    dev_wd_d   = pr_wd;
                    // Strobe is registered so it lands on the first ACCESS cycle.
                    for (int i = 0; i < NDEV; i++) begin
                        if (addr_slot == 3'(i)) begin
                            dev_we_d[i] = addr_hit && pr_we;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (dev_read) begin
                    if (wcnt_q == C_WAIT_LAST) begin
                        pr_rd_d    = dev_rd_sel;
                        pr_ready_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end else begin
                    pr_ready_d = 1'b1;
                    pr_err_d   = miss_q;
                    state_d    = S_DONE;
                    pr_rd_d    = '0;
                    if (miss_q) begin
                        if (errcnt_q != 8'hFF) begin
                            errcnt_d = errcnt_q + 8'd1;
                        end
                    end else if (ctrl_q && we_q) begin
                        case (dev_addr_q)
                            2'd0:    mask_d   = dev_wd_q[NDEV-1:0];
                            2'd1:    pend_clr = dev_wd_q[NDEV-1:0];
                            2'd2:    errcnt_d = '0;
                            default: pend_clr = '0;
                        endcase
                    end else if (ctrl_q) begin
                        pr_rd_d = ctrl_rd;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A set from a live interrupt beats a same-cycle W1C clear.
        pend_d   = (pend_q & ~pend_clr) | dev_irq;
        hw_int_d = '0;
        hw_int_d[NDEV-1:0] = pend_q & mask_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            miss_q     <= 1'b0;
            ctrl_q     <= 1'b0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
            dev_we_q   <= '0;
            pr_rd_q    <= '0;
            pr_ready_q <= 1'b0;
            pr_err_q   <= 1'b0;
            mask_q     <= '0;
            pend_q     <= '0;
            errcnt_q   <= '0;
            hw_int_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            miss_q     <= miss_d;
            ctrl_q     <= ctrl_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
            dev_we_q   <= dev_we_d;
            pr_rd_q    <= pr_rd_d;
            pr_ready_q <= pr_ready_d;
            pr_err_q   <= pr_err_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            errcnt_q   <= errcnt_d;
            hw_int_q   <= hw_int_d;
        end
    end

    assign pr_rd    = pr_rd_q;
    assign pr_ready = pr_ready_q;
    assign pr_err   = pr_err_q;
    assign dev_addr = dev_addr_q;
    assign dev_wd   = dev_wd_q;
    assign dev_we   = dev_we_q;
    assign hw_int   = hw_int_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_bridge_n
//  Description : Scoreboard bench for sys_bridge_n (NDEV=3, WAIT=1) plus a
//                WAIT=0 instance for the short read-latency case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_bridge_n;

    localparam logic [31:0] C_BASE = 32'h0000_7F00;
    localparam logic [31:0] C_MASK = C_BASE + 32'h30;
    localparam logic [31:0] C_PEND = C_BASE + 32'h34;
    localparam logic [31:0] C_ECNT = C_BASE + 32'h38;
    localparam logic [31:0] C_W3   = C_BASE + 32'h3C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pr_req = 1'b0;
    logic        pr_req0 = 1'b0;
    logic        pr_we = 1'b0;
    logic [31:0] pr_addr = '0;
    logic [31:0] pr_wd = '0;
    logic [95:0] dev_rd;
    logic [2:0]  dev_irq = '0;

    logic [31:0] pr_rd, pr_rd0;
    logic        pr_ready, pr_ready0;
    logic        pr_err, pr_err0;
    logic [1:0]  dev_addr, dev_addr0;
    logic [31:0] dev_wd, dev_wd0;
    logic [2:0]  dev_we, dev_we0;
    logic [5:0]  hw_int, hw_int0;

    sys_bridge_n #(.NDEV(3), .WAIT(1), .BASE(C_BASE)) dut (
        .clk(clk), .rst(rst), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
        .pr_wd(pr_wd), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we), .dev_rd(dev_rd),
        .dev_irq(dev_irq), .hw_int(hw_int)
    );

    sys_bridge_n #(.NDEV(3), .WAIT(0), .BASE(C_BASE)) dut0 (
        .clk(clk), .rst(rst), .pr_req(pr_req0), .pr_we(pr_we), .pr_addr(pr_addr),
        .pr_wd(pr_wd), .pr_rd(pr_rd0), .pr_ready(pr_ready0), .pr_err(pr_err0),
        .dev_addr(dev_addr0), .dev_wd(dev_wd0), .dev_we(dev_we0), .dev_rd(dev_rd),
        .dev_irq(dev_irq), .hw_int(hw_int0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          req_cyc;
        int          lat;
    } sb_t;

    sb_t  sb[$];
    sb_t  e_mon;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   we_pulses = 0;
    logic [2:0] last_we = '0;
    int   last_we_cyc = 0;
    int   errcnt_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Completion monitor: every pr_ready pops one expectation.
    always @(negedge clk) begin
        if (pr_err) chk("err_needs_ready", 32'(pr_ready), 32'd1);
        if (pr_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 32'(pr_ready), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("rd_data", pr_rd, e_mon.rd);
                chk("err_flag", 32'(pr_err), 32'(e_mon.err));
                chk("latency", 32'(cyc - e_mon.req_cyc), 32'(e_mon.lat));
            end
        end
        if (dev_we != 3'b000) begin
            we_pulses++;
            last_we     = dev_we;
            last_we_cyc = cyc;
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic err, input int rc, input int lat);
        sb_t e;
        e.rd = rd; e.err = err; e.req_cyc = rc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("completion_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int lat);
        pr_req = 1'b1; pr_we = we; pr_addr = addr; pr_wd = wd;
        push_exp(erd, eerr, cyc, lat);
        @(negedge clk);
        pr_req = 1'b0;
        wait_done();
    endtask

    task automatic miss_read(input logic [31:0] addr);
        if (errcnt_m < 255) errcnt_m++;
        issue(1'b0, addr, 32'h0, 32'h0, 1'b1, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        dev_rd = {32'h0000_1234, 32'h0000_B1B1, 32'h0000_A0A0};

        repeat (3) @(negedge clk);
        chk("rst_pr_rd", pr_rd, 32'h0);
        chk("rst_ready", 32'(pr_ready), 32'd0);
        chk("rst_dev_we", 32'(dev_we), 32'd0);
        chk("rst_hw_int", 32'(hw_int), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Device write: one-hot strobe on the first ACCESS cycle.
        n = cyc; p0 = we_pulses;
        issue(1'b1, C_BASE + 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        chk("wr_we_count", 32'(we_pulses - p0), 32'd1);
        chk("wr_we_value", 32'(last_we), 32'h2);
        chk("wr_we_cycle", 32'(last_we_cyc - n), 32'd1);
        chk("wr_dev_addr", 32'(dev_addr), 32'd1);
        chk("wr_dev_wd", dev_wd, 32'hDEAD_BEEF);

        // Device reads with WAIT=1, plus hold of pr_rd afterwards.
        p0 = we_pulses;
        issue(1'b0, C_BASE + 32'h28, 32'h0, 32'h0000_1234, 1'b0, 3);
        issue(1'b0, C_BASE + 32'h04, 32'h0, 32'h0000_A0A0, 1'b0, 3);
        repeat (3) @(negedge clk);
        chk("rd_hold", pr_rd, 32'h0000_A0A0);
        chk("rd_no_we", 32'(we_pulses - p0), 32'd0);

        // WAIT=0 instance: device read completes one cycle sooner.
        pr_req0 = 1'b1; pr_we = 1'b0; pr_addr = C_BASE + 32'h28; n = cyc;
        @(negedge clk);
        pr_req0 = 1'b0;
        for (int k = 0; k < 10 && !pr_ready0; k++) @(negedge clk);
        chk("wait0_latency", 32'(cyc - n), 32'd2);
        chk("wait0_rd", pr_rd0, 32'h0000_1234);
        repeat (2) @(negedge clk);

        // Misses, window boundaries and the saturating error counter.
        miss_read(32'h0000_0000);
        issue(1'b0, C_ECNT, 32'h0, 32'(errcnt_m), 1'b0, 2);
        miss_read(C_BASE + 32'h40);
        miss_read(C_BASE - 32'h4);
        issue(1'b0, C_ECNT, 32'h0, 32'(errcnt_m), 1'b0, 2);
        issue(1'b1, C_ECNT, 32'h0, 32'h0, 1'b0, 2);
        errcnt_m = 0;
        issue(1'b0, C_ECNT, 32'h0, 32'h0, 1'b0, 2);
        for (int k = 0; k < 300; k++) miss_read(32'h0000_1000 + 32'(4 * k));
        issue(1'b0, C_ECNT, 32'h0, 32'(errcnt_m), 1'b0, 2);
        issue(1'b1, C_ECNT, 32'h5, 32'h0, 1'b0, 2);
        errcnt_m = 0;
        issue(1'b0, C_ECNT, 32'h0, 32'h0, 1'b0, 2);
        issue(1'b1, C_W3, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
        issue(1'b0, C_W3, 32'h0, 32'h0, 1'b0, 2);

        // Interrupt aggregation: MASK=101, pulse irq[1:0].
        issue(1'b1, C_MASK, 32'h5, 32'h0, 1'b0, 2);
        issue(1'b0, C_MASK, 32'h0, 32'h5, 1'b0, 2);
        dev_irq = 3'b011;
        @(negedge clk);
        dev_irq = 3'b000;
        chk("hw_int_lag", 32'(hw_int), 32'h0);
        @(negedge clk);
        chk("hw_int_masked", 32'(hw_int), 32'h1);
        issue(1'b0, C_PEND, 32'h0, 32'h3, 1'b0, 2);
        dev_irq = 3'b001;
        issue(1'b1, C_PEND, 32'h3, 32'h0, 1'b0, 2);
        issue(1'b0, C_PEND, 32'h0, 32'h1, 1'b0, 2);
        dev_irq = 3'b000;
        issue(1'b1, C_PEND, 32'h1, 32'h0, 1'b0, 2);
        issue(1'b0, C_PEND, 32'h0, 32'h0, 1'b0, 2);
        chk("hw_int_cleared", 32'(hw_int), 32'h0);
        dev_irq = 3'b100;
        @(negedge clk);
        dev_irq = 3'b000;
        issue(1'b0, C_PEND, 32'h0, 32'h4, 1'b0, 2);
        chk("hw_int_bit2", 32'(hw_int), 32'h4);
        issue(1'b0, C_MASK, 32'h0, 32'h5, 1'b0, 2);

        // Reset during the second ACCESS cycle of a device read.
        pr_req = 1'b1; pr_we = 1'b0; pr_addr = C_BASE + 32'h28;
        @(negedge clk);
        pr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pr_rd", pr_rd, 32'h0);
        chk("abort_ready", 32'(pr_ready), 32'd0);
        chk("abort_dev_addr", 32'(dev_addr), 32'd0);
        chk("abort_dev_wd", dev_wd, 32'h0);
        chk("abort_hw_int", 32'(hw_int), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, C_BASE + 32'h28, 32'h0, 32'h0000_1234, 1'b0, 3);
        issue(1'b0, C_MASK, 32'h0, 32'h0, 1'b0, 2);
        issue(1'b0, C_PEND, 32'h0, 32'h0, 1'b0, 2);

        // pr_req held across two back-to-back device writes.
        n = cyc; p0 = we_pulses;
        pr_req = 1'b1; pr_we = 1'b1; pr_addr = C_BASE; pr_wd = 32'h1111_1111;
        push_exp(32'h0, 1'b0, n, 2);
        push_exp(32'h0, 1'b0, n + 3, 2);
        @(negedge clk);
        chk("b2b_we_first", 32'(dev_we), 32'h1);
        pr_addr = C_BASE + 32'h24; pr_wd = 32'h2222_2222;
        @(negedge clk);
        chk("b2b_we_gap", 32'(dev_we), 32'h0);
        chk("b2b_wd_first", dev_wd, 32'h1111_1111);
        @(negedge clk);
        @(negedge clk);
        pr_req = 1'b0;
        chk("b2b_we_second", 32'(dev_we), 32'h4);
        wait_done();
        chk("b2b_we_count", 32'(we_pulses - p0), 32'd2);
        chk("b2b_wd_second", dev_wd, 32'h2222_2222);
        chk("b2b_dev_addr", 32'(dev_addr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
